// File: rtl/comm_pkg.sv
// Shared types and constants for the host command link endpoint.
package comm_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {ASM_WAIT_HI, ASM_WAIT_LO}             asm_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT}                    tx_state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic        IDLE_LVL   = 1'b1;

endpackage

// File: rtl/comm_slave_if.sv
// Command/response bus between the host serial pins, the endpoint and the command processor.
interface comm_slave_if;
    import comm_pkg::*;

    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;

    modport slave (
        input  RX, clr_cmd_rdy, resp, send_resp,
        output TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err
    );

    modport master (
        output RX, clr_cmd_rdy, resp, send_resp,
        input  TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err
    );

endinterface

// File: rtl/comm_uart_rx.sv
// 8N1 byte receiver: synchronises RX, detects start, samples mid-bit, flags framing errors.
module comm_uart_rx
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr,
    output logic       rx_start_o
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

    logic       rx_s1_q, rx_s2_q, rx_prev_q, fall_q;
    rx_state_t  state_q;
    logic [11:0] cnt_q;
    logic [3:0] bit_q;
    logic [7:0] shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= IDLE_LVL;
            rx_s2_q    <= IDLE_LVL;
            rx_prev_q  <= IDLE_LVL;
            fall_q     <= 1'b0;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            rx_data    <= '0;
            rx_vld     <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_start_o <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            fall_q     <= rx_prev_q & ~rx_s2_q;
            rx_vld     <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_start_o <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (fall_q) begin
                        state_q    <= RX_START;
                        cnt_q      <= '0;
                        rx_start_o <= 1'b1;
                    end
                end
                RX_START: begin
                    // Line back high at mid-start means a glitch, not a frame.
                    if (cnt_q == BAUD_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s2_q, shreg_q[7:1]};
                        if (bit_q == 4'd7) state_q <= RX_STOP;
                        else               bit_q   <= bit_q + 4'd1;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            rx_data <= shreg_q;
                            rx_vld  <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/comm_slave.sv
// Device-side command link endpoint: assembles 2-byte commands from RX, serialises response bytes on TX.
module comm_slave
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic         clk,
    input  logic         rst,
    comm_slave_if.slave  bus
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

    logic [7:0] rx_data;
    logic       rx_vld, rx_ferr, rx_start;

    comm_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (bus.RX),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_ferr    (rx_ferr),
        .rx_start_o (rx_start)
    );

    asm_state_t  asm_q;
    logic [7:0]  hi_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= ASM_WAIT_HI;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            if (bus.clr_cmd_rdy || (rx_start && asm_q == ASM_WAIT_HI))
                cmd_rdy_q <= 1'b0;
            // Completion is assigned last so it overrides a same-cycle acknowledge.
            if (rx_ferr) begin
                asm_q <= ASM_WAIT_HI;
            end else if (rx_vld) begin
                case (asm_q)
                    ASM_WAIT_HI: begin
                        hi_q  <= rx_data;
                        asm_q <= ASM_WAIT_LO;
                    end
                    ASM_WAIT_LO: begin
                        cmd_q     <= {hi_q, rx_data};
                        cmd_rdy_q <= 1'b1;
                        asm_q     <= ASM_WAIT_HI;
                    end
                    default: asm_q <= ASM_WAIT_HI;
                endcase
            end
        end
    end

    tx_state_t                 tx_state_q;
    logic [FRAME_BITS-1:0]     tx_shreg_q;
    logic [11:0]               tx_cnt_q;
    logic [3:0]                tx_bit_q;
    logic                      tx_q, tx_busy_q, resp_sent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_shreg_q  <= '1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_q        <= IDLE_LVL;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        tx_shreg_q <= {IDLE_LVL, bus.resp, 1'b0};
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (tx_cnt_q == BAUD_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == LAST_BIT) begin
                            tx_q        <= IDLE_LVL;
                            tx_busy_q   <= 1'b0;
                            resp_sent_q <= 1'b1;
                            tx_state_q  <= TX_IDLE;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_q       <= tx_shreg_q[1];
                            tx_shreg_q <= {IDLE_LVL, tx_shreg_q[FRAME_BITS-1:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 12'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign bus.TX        = tx_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.resp_sent = resp_sent_q;
    assign bus.frm_err   = rx_ferr;

endmodule
